wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back stage plus architectural register file for the 5-stage MIPS pipeline.
- Consumes the MEM/WB pipeline register outputs and selects the write-back value (load data vs ALU result).
- Commits that value to the 32-entry register file and serves the two ID-stage read ports.
- Provides same-cycle write-to-read bypass, so an instruction in ID sees a value being written back in the same cycle.

Parameters:
- DATA_W, 32, register and data width in bits
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W (32)

Ports:
- clk  input  1  pipeline clock, rising-edge
- rst  input  1  synchronous active-high reset
- MEMtoWB_ReadData  input  DATA_W  data-memory load result
- MEMtoWB_ALU_result  input  DATA_W  ALU result
- MEMtoWB_RegDest  input  ADDR_W  destination register number
- MEMtoWB_MemtoReg  input  1  1 = write load data, 0 = write ALU result
- MEMtoWB_RegWrite  input  1  write enable from control
- ID_rs  input  ADDR_W  read port 1 address
- ID_rt  input  ADDR_W  read port 2 address
- ID_ReadData1  output  DATA_W  read port 1 data (combinational)
- ID_ReadData2  output  DATA_W  read port 2 data (combinational)
- WB_WriteData  output  DATA_W  selected write-back value (combinational; for forwarding unit)
- WB_WriteEn  output  1  effective write enable (combinational; for forwarding unit)
- WB_WriteCount  output  32  count of committed register writes (debug)

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - On a rising edge with rst=1, all NUM_REGS entries are cleared to 0 and WB_WriteCount is cleared to 0.
  - Any write presented in that cycle is discarded.
  - While rst=1, ID_ReadData1, ID_ReadData2, WB_WriteData and WB_WriteEn are forced to 0.
- Write-back mux: WB_WriteData = MEMtoWB_MemtoReg ? MEMtoWB_ReadData : MEMtoWB_ALU_result.
- Effective enable: WB_WriteEn = MEMtoWB_RegWrite & (MEMtoWB_RegDest != 0) & ~rst.
- Commit:
  - On a rising edge with WB_WriteEn=1, reg[MEMtoWB_RegDest] <= WB_WriteData and WB_WriteCount increments by 1.
  - WB_WriteCount wraps from 0xFFFFFFFF to 0.
  - Latency: the value is visible in the array on the cycle after the edge.
- $zero: reg[0] is never written and always reads 0. A write to register 0 with RegWrite=1 is dropped and is not counted.
- Read ports (combinational, per port, priority order):
  - rst=1 -> 0
  - address 0 -> 0
  - WB_WriteEn=1 and address == MEMtoWB_RegDest -> WB_WriteData (bypass)
  - otherwise -> array contents
- Simultaneous events:
  - Both read ports may address the same register, including the one being written; both are bypassed.
  - A write and a reset in the same cycle: reset wins.
- Reset mid-operation: no pending state other than the array and the counter; the first cycle after rst deasserts behaves normally.
- Inputs are sampled only at the clock edge. No X propagation from an unused mux leg: the unselected source has no effect.

Decomposition:
- Shared package mips_pkg holds DATA_W/ADDR_W defaults and the REG_ZERO = 0 constant.
- One natural sub-module, regfile_2r1w: a 32x32 array with synchronous reset, one write port, two combinational read ports and the zero-register rule.
- wb_regfile instantiates regfile_2r1w and adds the WB mux, bypass, enable qualification and counter.

Test Plan:
- Reset: hold rst=1 for 2 cycles with RegWrite=1, RegDest=5, ALU=0xDEADBEEF -> ID_ReadData1 (rs=5) = 0, WB_WriteCount = 0 after release.
- ALU write then read: RegWrite=1, MemtoReg=0, RegDest=8, ALU=0x12345678; next cycle rs=8 -> 0x12345678; WB_WriteCount = 1.
- Load write with bypass: RegWrite=1, MemtoReg=1, ReadData=0xCAFEF00D, RegDest=9, rs=rt=9 in the same cycle -> both read ports = 0xCAFEF00D before the edge; array holds it after the edge.
- $zero: RegWrite=1, RegDest=0, ALU=0xFFFFFFFF -> WB_WriteEn=0, rs=0 reads 0, count unchanged.
- Write disabled: RegWrite=0, RegDest=8, ALU=0x1 with reg8 = 0x12345678 -> reg8 unchanged, no bypass, count unchanged.
- Write during reset: rst=1 with RegWrite=1, RegDest=3, ALU=0x77 -> reg3 = 0 after release, count = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline blocks.
// Holds the default datapath widths and the hard-wired zero register number.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // Register 0 is $zero: it is never written and always reads 0.
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage : mips_pkg

// File: rtl/regfile_2r1w.sv
// Architectural register array: 2**ADDR_W entries of DATA_W bits.
// One synchronous write port and two combinational read ports. Register 0 is
// hard-wired to zero on both the write side and the read side.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset, clears every entry
//   we      write enable (a write to register 0 is ignored)
//   waddr   write address
//   wdata   write data
//   raddr1  read port 1 address
//   raddr2  read port 2 address
//   rdata1  read port 1 data (array contents, no bypass)
//   rdata2  read port 2 data (array contents, no bypass)
module regfile_2r1w
  import mips_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  localparam int NUM_REGS = 2 ** AW;
  localparam logic [AW-1:0] ZERO_ADDR = '0;

  logic [DW-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != ZERO_ADDR)) begin
      regs[waddr] <= wdata;
    end
  end

  // Entry 0 is never written, but the explicit zero on read keeps $zero
  // correct even if the array came up with unknown contents before reset.
  assign rdata1 = (raddr1 == ZERO_ADDR) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == ZERO_ADDR) ? '0 : regs[raddr2];

endmodule : regfile_2r1w

// File: rtl/wb_regfile.sv
// Write-back stage plus architectural register file.
// Selects the write-back value from the MEM/WB register (load data or ALU
// result), commits it to the register file, and serves the two ID read ports
// with same-cycle write-to-read bypass. Also keeps a committed-write counter.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   MEMtoWB_ReadData    data-memory load result
//   MEMtoWB_ALU_result  ALU result
//   MEMtoWB_RegDest     destination register number
//   MEMtoWB_MemtoReg    1 = write load data, 0 = write ALU result
//   MEMtoWB_RegWrite    write enable from control
//   ID_rs, ID_rt        read port addresses
//   ID_ReadData1/2      read port data (combinational, bypassed)
//   WB_WriteData        selected write-back value (combinational)
//   WB_WriteEn          qualified write enable (combinational)
//   WB_WriteCount       number of committed register writes, wraps at 2**32
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] MEMtoWB_ReadData,
  input  logic [DW-1:0] MEMtoWB_ALU_result,
  input  logic [AW-1:0] MEMtoWB_RegDest,
  input  logic          MEMtoWB_MemtoReg,
  input  logic          MEMtoWB_RegWrite,
  input  logic [AW-1:0] ID_rs,
  input  logic [AW-1:0] ID_rt,
  output logic [DW-1:0] ID_ReadData1,
  output logic [DW-1:0] ID_ReadData2,
  output logic [DW-1:0] WB_WriteData,
  output logic          WB_WriteEn,
  output logic [31:0]   WB_WriteCount
);

  localparam logic [AW-1:0] ZERO_ADDR = '0;

  logic [DW-1:0] wb_value;
  logic          wr_en;
  logic [DW-1:0] arr_data1;
  logic [DW-1:0] arr_data2;
  logic [31:0]   write_count;

  assign wb_value = MEMtoWB_MemtoReg ? MEMtoWB_ReadData : MEMtoWB_ALU_result;

  // Writes to $zero and writes during reset are not real commits, so they
  // neither reach the array nor show up to the forwarding unit.
  assign wr_en = MEMtoWB_RegWrite && (MEMtoWB_RegDest != ZERO_ADDR) && !rst;

  regfile_2r1w #(
    .DW(DW),
    .AW(AW)
  ) u_regs (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (MEMtoWB_RegDest),
    .wdata (wb_value),
    .raddr1(ID_rs),
    .raddr2(ID_rt),
    .rdata1(arr_data1),
    .rdata2(arr_data2)
  );

  // Per-port read priority: reset, $zero, bypass of the in-flight write,
  // then the stored array value.
  always_comb begin
    ID_ReadData1 = arr_data1;
    if (rst || (ID_rs == ZERO_ADDR)) begin
      ID_ReadData1 = '0;
    end else if (wr_en && (ID_rs == MEMtoWB_RegDest)) begin
      ID_ReadData1 = wb_value;
    end
  end

  always_comb begin
    ID_ReadData2 = arr_data2;
    if (rst || (ID_rt == ZERO_ADDR)) begin
      ID_ReadData2 = '0;
    end else if (wr_en && (ID_rt == MEMtoWB_RegDest)) begin
      ID_ReadData2 = wb_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_count <= '0;
    end else if (wr_en) begin
      write_count <= write_count + 32'd1;
    end
  end

  assign WB_WriteData  = rst ? '0 : wb_value;
  assign WB_WriteEn    = wr_en;
  assign WB_WriteCount = write_count;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios followed by random
// traffic, all compared against a behavioural register-file model.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] mem_rdata;
  logic [31:0] alu_result;
  logic [4:0]  reg_dest;
  logic        mem_to_reg;
  logic        reg_write;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] wb_data;
  logic        wb_en;
  logic [31:0] wb_count;

  wb_regfile dut (
    .clk               (clk),
    .rst               (rst),
    .MEMtoWB_ReadData  (mem_rdata),
    .MEMtoWB_ALU_result(alu_result),
    .MEMtoWB_RegDest   (reg_dest),
    .MEMtoWB_MemtoReg  (mem_to_reg),
    .MEMtoWB_RegWrite  (reg_write),
    .ID_rs             (id_rs),
    .ID_rt             (id_rt),
    .ID_ReadData1      (rd1),
    .ID_ReadData2      (rd2),
    .WB_WriteData      (wb_data),
    .WB_WriteEn        (wb_en),
    .WB_WriteCount     (wb_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst        = 1'b1;
    mem_rdata  = '0;
    alu_result = '0;
    reg_dest   = '0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    id_rs      = '0;
    id_rt      = '0;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_regs [32];
  logic [31:0] ref_count;
  bit          ref_known;   // count is defined only after the first reset edge

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  logic [31:0] last_rd1, last_rd2, last_cnt;
  logic        last_wen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic r,
                                             input logic commit, input logic [31:0] v);
    if (r) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (commit && a == reg_dest) return v;
    return ref_regs[a];
  endfunction

  // ---------------- driver ----------------
  // Apply one cycle of inputs, check combinational outputs before the edge,
  // then advance the model across the edge.
  task automatic drive(input logic r, input logic rw, input logic m2r,
                       input logic [4:0] dest, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rdata, input logic [31:0] alu);
    logic [31:0] value;
    logic        commit;
    @(negedge clk);
    rst        = r;
    reg_write  = rw;
    mem_to_reg = m2r;
    reg_dest   = dest;
    id_rs      = rs;
    id_rt      = rt;
    mem_rdata  = rdata;
    alu_result = alu;
    #1;
    value  = m2r ? rdata : alu;
    commit = rw && (dest != 5'd0) && !r;
    exp_q.push_back(model_read(rs, r, commit, value));
    exp_q.push_back(model_read(rt, r, commit, value));
    exp_q.push_back(r ? 32'h0 : value);
    exp_q.push_back({31'h0, commit});
    last_rd1 = rd1;
    last_rd2 = rd2;
    last_wen = wb_en;
    last_cnt = wb_count;
    check("rd1", rd1, exp_q.pop_front());
    check("rd2", rd2, exp_q.pop_front());
    check("wb_data", wb_data, exp_q.pop_front());
    check("wb_en", {31'h0, wb_en}, exp_q.pop_front());
    if (ref_known) check("count", wb_count, ref_count);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
      ref_count = 32'h0;
      ref_known = 1'b1;
    end else if (commit) begin
      ref_regs[dest] = value;
      ref_count      = ref_count + 32'd1;
    end
  endtask

  task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
    drive(1'b0, 1'b0, 1'b0, 5'd0, rs, rt, 32'h0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] d;
    ref_known = 1'b0;
    ref_count = 32'h0;
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;

    // Reset held two cycles with a write presented.
    drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 32'h0, 32'hDEADBEEF);
    check("rst_rd1_zero", last_rd1, 32'h0);
    check("rst_wen_zero", {31'h0, last_wen}, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 32'h0, 32'hDEADBEEF);
    idle(5'd5, 5'd3);
    check("rst_reg5", last_rd1, 32'h0);
    check("rst_count", last_cnt, 32'h0);

    // ALU write then read.
    drive(1'b0, 1'b1, 1'b0, 5'd8, 5'd1, 5'd2, 32'h0, 32'h12345678);
    idle(5'd8, 5'd0);
    check("alu_read", last_rd1, 32'h12345678);
    check("alu_count", last_cnt, 32'd1);

    // Load write with bypass on both ports.
    drive(1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 32'hCAFEF00D, 32'h0BADBAD0);
    check("byp_rd1", last_rd1, 32'hCAFEF00D);
    check("byp_rd2", last_rd2, 32'hCAFEF00D);
    idle(5'd9, 5'd8);
    check("load_stored", last_rd1, 32'hCAFEF00D);

    // Write to $zero is dropped.
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'hFFFFFFFF);
    check("zero_wen", {31'h0, last_wen}, 32'h0);
    check("zero_rd", last_rd1, 32'h0);
    idle(5'd0, 5'd8);
    check("zero_count", last_cnt, 32'd2);

    // Disabled write: no bypass, no change.
    drive(1'b0, 1'b0, 1'b0, 5'd8, 5'd8, 5'd8, 32'h0, 32'h1);
    check("dis_nobyp", last_rd1, 32'h12345678);
    idle(5'd8, 5'd8);
    check("dis_keep", last_rd1, 32'h12345678);
    check("dis_count", last_cnt, 32'd2);

    // Write during reset loses to reset.
    drive(1'b0, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 32'h0, 32'h55);
    drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd3, 5'd3, 32'h0, 32'h77);
    idle(5'd3, 5'd8);
    check("rstw_reg3", last_rd1, 32'h0);
    check("rstw_reg8", last_rd2, 32'h0);
    check("rstw_count", last_cnt, 32'h0);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      d = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            d,
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
            $urandom, $urandom);
    end

    // Sweep every register to compare the array against the model.
    for (int i = 0; i < 32; i += 2) begin
      idle(5'(i), 5'(i + 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net in case the stimulus stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got stalled expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_wb_regfile
